fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Instruction-fetch controller for the 8-bit pipelined processor.
- Drives the PC into instr_mem and consumes its instr/next_byte pair.
- Decodes the instruction length (1 or 2 bytes), advances the PC, and loads the IF/ID pipeline register.
- Handles decode-stage stall, branch/jump redirect (flush) and the halt opcode.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset when the reset-vector feature is absent.
- HLT_OP, 8'h01, opcode that halts fetch.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_o  out  8  current fetch address to instr_mem.PC.
- instr_i  in  8  instr_mem.instr = M[pc_o], combinational.
- next_byte_i  in  8  instr_mem.next_byte = M[(pc_o+1) mod 256], combinational.
- stall_i  in  1  decode stage cannot accept; hold PC and IF/ID.
- redirect_i  in  1  taken branch/jump/interrupt; flush and reload PC.
- redirect_pc_i  in  8  redirect target.
- ifid_valid_o  out  1  IF/ID register holds a real instruction.
- ifid_instr_o  out  8  opcode byte.
- ifid_imm_o  out  8  second byte for 2-byte instructions, else 8'h00.
- ifid_pc_o  out  8  address of the instruction in IF/ID.
- ifid_pc_next_o  out  8  address of the following instruction (return address for CALL).
- halted_o  out  1  fetch is in HALT.

Behaviour:
- Reset: all outputs are registered and reset as follows.
  - pc_o=RESET_PC; ifid_valid_o=0; ifid_instr_o, ifid_imm_o, ifid_pc_o, ifid_pc_next_o = 8'h00; halted_o=0.
  - State = RUN.
  - Reset dominates every other input, including mid-redirect and mid-halt.
- Length rule: 2-byte iff instr_i[7:4] >= 4'hC; otherwise 1-byte. len ∈ {1,2}.
- RUN, priority redirect > stall > normal. Actions per case:
  - redirect_i=1: pc_o<=redirect_pc_i; ifid_valid_o<=0; other IF/ID fields are don't-care but hold. This applies even when stall_i=1.
  - stall_i=1 (no redirect): pc_o and all IF/ID outputs hold their values.
  - normal, IF/ID load: ifid_instr_o<=instr_i; ifid_imm_o<=(len==2)?next_byte_i:0; ifid_pc_o<=pc_o; ifid_pc_next_o<=pc_o+len; ifid_valid_o<=1.
  - normal, PC update: pc_o<=pc_o+len.
  - normal, halt check: if instr_i==HLT_OP, state<=HALT and halted_o<=1. The HLT itself is still loaded into IF/ID with valid=1.
- HALT:
  - pc_o holds.
  - ifid_valid_o<=0 on the first non-stalled cycle, so HLT is presented exactly once; under stall, IF/ID holds.
  - Exit only via redirect_i: pc_o<=redirect_pc_i, state<=RUN, halted_o<=0, ifid_valid_o<=0.
- Latency: instruction at PC appears on IF/ID one clock after pc_o=PC, if not stalled. Sustained throughput is 1 instruction/cycle.
- Wrap-around: all PC arithmetic is mod 256.
  - 8'hFF + 1 = 8'h00.
  - A 2-byte op at 8'hFF takes its imm from M[8'h00], and next PC = 8'h01.
- Redirect to the current pc_o is legal and produces one bubble.

Optional Feature:
- Macro: FETCH_RESET_VEC_EN.
- With the macro, reset enters state VEC instead of RUN, with pc_o=8'h00 and ifid_valid_o=0. In VEC:
  - the next cycle loads pc_o<=instr_i (M[0] = start address) and enters RUN;
  - stall_i is ignored;
  - redirect_i overrides, taking redirect_pc_i.
- Without the macro: the VEC state does not exist, and reset goes straight to RUN at RESET_PC.

Decomposition:
- Package cpu_pkg holds:
  - state encoding typedef fetch_state_t {VEC, RUN, HALT};
  - constants OP_HLT=8'h01 and TWO_BYTE_MIN_NIBBLE=4'hC;
  - function is_two_byte(opcode).
- One natural sub-module, ifid_reg: the IF/ID pipeline register with load/hold/flush controls. Next-PC logic stays in fetch_ctrl.

Test Plan:
- Sequential fetch: M = {8'h10, 8'hC2, 8'h55, 8'h20}, RESET_PC=0. Expected IF/ID sequence: (pc00, 10, imm00, next01), (pc01, C2, imm55, next03), (pc03, 20, imm00, next04).
- Stall: assert stall_i for 3 cycles after the first load. Expected: pc_o and IF/ID frozen, valid stays 1, and fetch resumes with no lost or duplicated instruction.
- Redirect with simultaneous stall: redirect_i=1, stall_i=1, redirect_pc_i=8'h40. Expected: next cycle pc_o=8'h40 and ifid_valid_o=0; the following cycle shows the instruction at 8'h40.
- Halt: M[5]=8'h01. Expected: HLT appears once with valid=1, then valid=0 and halted_o=1 with pc_o held at 06. A redirect to 8'h00 resumes fetch.
- Wrap: M[FF]=8'hD0, M[00]=8'h7A, pc at FF. Expected: ifid_imm_o=8'h7A, ifid_pc_next_o=8'h01, pc_o=8'h01.
- FETCH_RESET_VEC_EN with M[0]=8'h20: release reset. Expected: one cycle in VEC, then pc_o=8'h20, and the first valid instruction has ifid_pc_o=8'h20. Asserting reset mid-run returns to VEC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch stage.
// Optional macro FETCH_RESET_VEC_EN adds the VEC reset-vector state.
package cpu_pkg;

  localparam logic [7:0] OP_HLT = 8'h01;
  localparam logic [3:0] TWO_BYTE_MIN_NIBBLE = 4'hC;

`ifdef FETCH_RESET_VEC_EN
  typedef enum logic [1:0] {
    VEC  = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;
`else
  typedef enum logic [1:0] {
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;
`endif

  function automatic logic is_two_byte(input logic [7:0] opcode);
    return opcode[7:4] >= TWO_BYTE_MIN_NIBBLE;
  endfunction

endpackage

// File: rtl/fetch_ctrl_ifid_reg.sv
// IF/ID pipeline register: load, hold, or flush (valid only).
// Flush leaves the payload untouched; only valid is cleared.
module ifid_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       flush,
  input  logic [7:0] instr_d,
  input  logic [7:0] imm_d,
  input  logic [7:0] pc_d,
  input  logic [7:0] pc_next_d,
  output logic       valid,
  output logic [7:0] instr,
  output logic [7:0] imm,
  output logic [7:0] pc,
  output logic [7:0] pc_next
);

  // reset > flush > load > hold
  always_ff @(posedge clk) begin
    if (rst) begin
      valid   <= 1'b0;
      instr   <= 8'h00;
      imm     <= 8'h00;
      pc      <= 8'h00;
      pc_next <= 8'h00;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      instr   <= instr_d;
      imm     <= imm_d;
      pc      <= pc_d;
      pc_next <= pc_next_d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: PC sequencing, length decode, stall/redirect/halt.
// Optional macro FETCH_RESET_VEC_EN: reset loads PC from M[0] via VEC.
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [7:0] HLT_OP   = OP_HLT
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] pc_o,
  input  logic [7:0] instr_i,
  input  logic [7:0] next_byte_i,
  input  logic       stall_i,
  input  logic       redirect_i,
  input  logic [7:0] redirect_pc_i,
  output logic       ifid_valid_o,
  output logic [7:0] ifid_instr_o,
  output logic [7:0] ifid_imm_o,
  output logic [7:0] ifid_pc_o,
  output logic [7:0] ifid_pc_next_o,
  output logic       halted_o
);

  fetch_state_t state_q, state_d;
  logic [7:0]   pc_q, pc_d;
  logic         load, flush;
  logic         two_byte;
  logic [7:0]   pc_inc;
  logic [7:0]   imm;

  assign two_byte = is_two_byte(instr_i);
  assign pc_inc   = pc_q + (two_byte ? 8'd2 : 8'd1);
  assign imm      = two_byte ? next_byte_i : 8'h00;

  // State and PC registers; reset dominates everything
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef FETCH_RESET_VEC_EN
      state_q <= VEC;
      pc_q    <= 8'h00;
`else
      state_q <= RUN;
      pc_q    <= RESET_PC;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state, next-PC and IF/ID control
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
`ifdef FETCH_RESET_VEC_EN
      VEC: begin
        flush   = 1'b1;
        state_d = RUN;
        pc_d    = redirect_i ? redirect_pc_i : instr_i;
      end
`endif
      RUN: begin
        if (redirect_i) begin
          pc_d  = redirect_pc_i;
          flush = 1'b1;
        end else if (!stall_i) begin
          pc_d = pc_inc;
          load = 1'b1;
          if (instr_i == HLT_OP) begin
            state_d = HALT;
          end
        end
      end
      HALT: begin
        if (redirect_i) begin
          pc_d    = redirect_pc_i;
          state_d = RUN;
          flush   = 1'b1;
        end else if (!stall_i) begin
          flush = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        flush   = 1'b1;
      end
    endcase
  end

  assign pc_o     = pc_q;
  assign halted_o = (state_q == HALT);

  ifid_reg u_ifid (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .flush     (flush),
    .instr_d   (instr_i),
    .imm_d     (imm),
    .pc_d      (pc_q),
    .pc_next_d (pc_inc),
    .valid     (ifid_valid_o),
    .instr     (ifid_instr_o),
    .imm       (ifid_imm_o),
    .pc        (ifid_pc_o),
    .pc_next   (ifid_pc_next_o)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl.
// Build with FETCH_RESET_VEC_EN to exercise the VEC reset path.
module tb_fetch_ctrl;

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] instr;
    logic [7:0] imm;
    logic [7:0] pc_next;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pc_o;
  logic [7:0] instr_i;
  logic [7:0] next_byte_i;
  logic       stall_i = 1'b0;
  logic       redirect_i = 1'b0;
  logic [7:0] redirect_pc_i = 8'h00;
  logic       ifid_valid_o;
  logic [7:0] ifid_instr_o;
  logic [7:0] ifid_imm_o;
  logic [7:0] ifid_pc_o;
  logic [7:0] ifid_pc_next_o;
  logic       halted_o;

  logic [7:0] mem [256];
  logic [7:0] pc_p1;
  exp_t       q [$];
  int         errors = 0;
  int         checks = 0;

  assign pc_p1       = pc_o + 8'd1;
  assign instr_i     = mem[pc_o];
  assign next_byte_i = mem[pc_p1];

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .pc_o           (pc_o),
    .instr_i        (instr_i),
    .next_byte_i    (next_byte_i),
    .stall_i        (stall_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .ifid_valid_o   (ifid_valid_o),
    .ifid_instr_o   (ifid_instr_o),
    .ifid_imm_o     (ifid_imm_o),
    .ifid_pc_o      (ifid_pc_o),
    .ifid_pc_next_o (ifid_pc_next_o),
    .halted_o       (halted_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] p, input logic [7:0] i,
                      input logic [7:0] m, input logic [7:0] n);
    exp_t e;
    e.pc      = p;
    e.instr   = i;
    e.imm     = m;
    e.pc_next = n;
    q.push_back(e);
  endtask

  // Monitor: decode accepts IF/ID when valid and not stalled
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (!rst && ifid_valid_o && !stall_i) begin
      a = {ifid_pc_o, ifid_instr_o, ifid_imm_o, ifid_pc_next_o};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ifid: got %h want none", a);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL ifid: got pc/ins/imm/nxt %h want %h", a, e);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
`ifdef FETCH_RESET_VEC_EN
    mem[8'h00] = 8'h20;
    mem[8'h20] = 8'h11;
    mem[8'h21] = 8'hC4;
    mem[8'h22] = 8'h66;
    rst = 1'b1;
    step();
    step();
    chk("vec_rst_pc", pc_o, 8'h00);
    chk("vec_rst_valid", {7'd0, ifid_valid_o}, 8'h00);
    push(8'h20, 8'h11, 8'h00, 8'h21);
    push(8'h21, 8'hC4, 8'h66, 8'h23);
    rst = 1'b0;
    stall_i = 1'b1;
    step();
    chk("vec_pc", pc_o, 8'h20);
    chk("vec_valid", {7'd0, ifid_valid_o}, 8'h00);
    stall_i = 1'b0;
    step();
    chk("vec_run_pc", pc_o, 8'h21);
    chk("vec_first_pc", ifid_pc_o, 8'h20);
    step();
    chk("vec_pc2", pc_o, 8'h23);
    chk("vec_imm", ifid_imm_o, 8'h66);
    step();
    rst = 1'b1;
    step();
    chk("vec_rerst_pc", pc_o, 8'h00);
    chk("vec_rerst_valid", {7'd0, ifid_valid_o}, 8'h00);
    rst = 1'b0;
    step();
    chk("vec_again_pc", pc_o, 8'h20);
    stall_i = 1'b1;
    step();
`else
    mem[8'h00] = 8'h10;
    mem[8'h01] = 8'hC2;
    mem[8'h02] = 8'h55;
    mem[8'h03] = 8'h20;
    mem[8'h04] = 8'h30;
    mem[8'h05] = 8'h01;
    mem[8'h40] = 8'hC5;
    mem[8'h41] = 8'h9A;
    mem[8'hFF] = 8'hD0;
    rst = 1'b1;
    step();
    step();
    chk("rst_pc", pc_o, 8'h00);
    chk("rst_valid", {7'd0, ifid_valid_o}, 8'h00);
    chk("rst_instr", ifid_instr_o, 8'h00);
    chk("rst_imm", ifid_imm_o, 8'h00);
    chk("rst_ifid_pc", ifid_pc_o, 8'h00);
    chk("rst_pc_next", ifid_pc_next_o, 8'h00);
    chk("rst_halted", {7'd0, halted_o}, 8'h00);
    push(8'h00, 8'h10, 8'h00, 8'h01);
    push(8'h01, 8'hC2, 8'h55, 8'h03);
    push(8'h03, 8'h20, 8'h00, 8'h04);
    push(8'h04, 8'h30, 8'h00, 8'h05);
    push(8'h05, 8'h01, 8'h00, 8'h06);
    rst = 1'b0;
    step();
    stall_i = 1'b1;
    chk("first_pc", pc_o, 8'h01);
    chk("first_valid", {7'd0, ifid_valid_o}, 8'h01);
    chk("first_ifid_pc", ifid_pc_o, 8'h00);
    for (int i = 0; i < 3; i++) step();
    chk("stall_pc", pc_o, 8'h01);
    chk("stall_instr", ifid_instr_o, 8'h10);
    chk("stall_valid", {7'd0, ifid_valid_o}, 8'h01);
    stall_i = 1'b0;
    for (int i = 0; i < 20 && !halted_o; i++) step();
    chk("halt_seen", {7'd0, halted_o}, 8'h01);
    chk("hlt_in_ifid", ifid_instr_o, 8'h01);
    step();
    chk("halt_valid", {7'd0, ifid_valid_o}, 8'h00);
    chk("halt_flag", {7'd0, halted_o}, 8'h01);
    chk("halt_pc", pc_o, 8'h06);
    step();
    step();
    chk("halt_pc_hold", pc_o, 8'h06);
    chk("halt_valid_hold", {7'd0, ifid_valid_o}, 8'h00);
    redirect_i = 1'b1;
    redirect_pc_i = 8'h00;
    step();
    redirect_i = 1'b0;
    chk("resume_pc", pc_o, 8'h00);
    chk("resume_valid", {7'd0, ifid_valid_o}, 8'h00);
    chk("resume_halted", {7'd0, halted_o}, 8'h00);
    push(8'h00, 8'h10, 8'h00, 8'h01);
    step();
    step();
    redirect_i = 1'b1;
    stall_i = 1'b1;
    redirect_pc_i = 8'h40;
    step();
    chk("redir_stall_pc", pc_o, 8'h40);
    chk("redir_stall_valid", {7'd0, ifid_valid_o}, 8'h00);
    redirect_i = 1'b0;
    stall_i = 1'b0;
    push(8'h40, 8'hC5, 8'h9A, 8'h42);
    step();
    chk("redir_tgt_pc", ifid_pc_o, 8'h40);
    redirect_i = 1'b1;
    redirect_pc_i = 8'hFF;
    step();
    redirect_i = 1'b0;
    chk("wrap_start_pc", pc_o, 8'hFF);
    mem[8'h00] = 8'h7A;
    push(8'hFF, 8'hD0, 8'h7A, 8'h01);
    step();
    chk("wrap_pc", pc_o, 8'h01);
    chk("wrap_imm", ifid_imm_o, 8'h7A);
    chk("wrap_pc_next", ifid_pc_next_o, 8'h01);
    redirect_i = 1'b1;
    redirect_pc_i = 8'h80;
    step();
    chk("redir_pc", pc_o, 8'h80);
    chk("redir_valid", {7'd0, ifid_valid_o}, 8'h00);
    rst = 1'b1;
    redirect_pc_i = 8'h33;
    step();
    chk("rst_dom_pc", pc_o, 8'h00);
    chk("rst_dom_valid", {7'd0, ifid_valid_o}, 8'h00);
    rst = 1'b0;
    redirect_i = 1'b0;
    stall_i = 1'b1;
    step();
`endif
    step();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
